ave_vol_div_scheduler: RTL
==========================

# ave_vol_div_scheduler

Time-multiplexes one sequential signed divider across the three phase-average target-voltage calculations (A, B, C). On each control-period trigger it snapshots the three summed target voltages and working link counts, then runs the divisions in the fixed order A→B→C. When all three are done it publishes the 16-bit per-link averages as one atomic set. It replaces three parallel pipelined dividers with one iterative divider, and sits between the phase target-voltage summation and the per-link modulation logic.

## Interface
- DIV_LAT, 33: cycles from divider start pulse to done pulse; the implementation and the sub-module must agree on this value.
- i_clk_20M  in  1  20 MHz system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_VCU_Mode  in  16  converter mode; 16'd0 = standby
- i_calc_start  in  1  one-cycle trigger, once per control period
- i_TargetVolA/B/C  in  32 signed  summed phase target voltage (dividend)
- i_LinkNumA/B/C_Work  in  16 unsigned  working link count (divisor)
- o_Ave_TargetVolA/B/C  out  16 signed  per-link average, saturated
- o_valid  out  1  one-cycle pulse when a new A/B/C set is published
- o_busy  out  1  high from the accepted trigger until o_valid
- o_div0_err  out  3  per phase {C,B,A}: the last set had divisor 0
- o_overrun  out  1  sticky; set when a trigger arrives while busy

## Operation
- FSM states: IDLE, ISSUE, WAIT, STORE, PUBLISH. A 2-bit phase index counts 0 = A, 1 = B, 2 = C.
- IDLE: wait for i_calc_start.
  - i_VCU_Mode == 0: all outputs clear to 0, o_div0_err clears, no o_valid.
  - Otherwise: snapshot all six inputs into registers, phase = 0, go to ISSUE.
- ISSUE: assert div_start for one cycle with the snapshot for the current phase, then go to WAIT.
- WAIT: hold until div_done, then go to STORE.
- STORE: saturate the quotient and write it into a shadow register.
  - Phase < 2: increment phase, go to ISSUE.
  - Phase 2: go to PUBLISH.
- PUBLISH: copy the three shadows to the outputs, pulse o_valid, return to IDLE.
- Arithmetic:
  - Signed dividend, unsigned divisor.
  - Quotient truncates toward zero.
  - Clamp to [-32768, 32767].
- Divisor 0: the divider is still started, but its result is discarded. Shadow is 0 and the corresponding o_div0_err bit is 1 in the published set. All err bits are updated only at PUBLISH.
- Trigger while o_busy: ignored, and o_overrun is set. o_overrun clears only on reset.
- Mode change mid-sequence: the sequence completes and publishes the results; the new mode takes effect at the next trigger.
- Input changes after the snapshot have no effect on the sequence in progress.

## Timing
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - snapshots, shadows and the sub-module cleared
- Trigger sampled at edge k: snapshot taken at k, div_start high in cycle k+1.
- Per-phase slot is DIV_LAT+2 cycles: ISSUE 1 + WAIT DIV_LAT + STORE 1.
- o_valid high in cycle k+1+3·(DIV_LAT+2). With the default DIV_LAT this is k+106.
- Earliest next accepted trigger is the cycle after o_valid.
- o_busy rises at k+1 and falls in the cycle after o_valid.
- Outputs change only in the o_valid cycle and are stable in between.
- Reset asserted mid-sequence: everything returns to reset values immediately and no o_valid is produced.

## Structure
- Shared package holds:
  - FSM state encoding
  - phase index type
  - DIV_LAT_DEFAULT
  - Q16_MAX = 32767 and Q16_MIN = -32768
- Sub-module `shift_div_seq`: radix-2 restoring divider on magnitudes with sign fix-up.
  - Handshake is start/done; done comes exactly DIV_LAT cycles after start.
  - Outputs a 32-bit signed quotient.
  - Ignores start while it is busy.
- The top level contains the FSM, snapshot registers, saturation logic and output registers.

## Test plan
- Plain divide: A=1000/4, B=-1000/3, C=7/7 with mode 1 → outputs 250, -333, 1; o_valid exactly 106 cycles after the trigger; o_div0_err = 000.
- Saturation: A=100000/1, B=-100000/1, C=65534/2 → outputs 32767, -32768, 32767.
- Divide by zero: B divisor 0, A=500/5, C=600/6 → outputs 100, 0, 100; o_div0_err = 3'b010.
- Overrun and snapshot: second trigger at +20 cycles, and i_TargetVolA changed at +5 → o_overrun = 1; results use the original snapshot; exactly one o_valid.
- Standby: mode 0 trigger after a valid set → outputs 0, o_div0_err 0, no o_valid, o_busy stays low.
- Reset mid-sequence: i_reset_n low at +50 cycles for 3 cycles → outputs 0, no o_valid; the next trigger then produces a correct set at +106 cycles.

Source files
------------

// File: rtl/ave_vol_div_scheduler_pkg.sv
// Shared types and constants for the time-multiplexed phase-average divider.
package ave_vol_div_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_STORE   = 3'd3,
        ST_PUBLISH = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_A = 2'd0,
        PH_B = 2'd1,
        PH_C = 2'd2
    } phase_t;

    localparam int DIV_LAT_DEFAULT = 33;
    localparam int Q16_MAX         = 32767;
    localparam int Q16_MIN         = -32768;

    function automatic logic signed [15:0] sat_q16(input logic signed [31:0] value);
        logic signed [15:0] result;
        if (value > 32'(Q16_MAX)) begin
            result = 16'(Q16_MAX);
        end else if (value < 32'(Q16_MIN)) begin
            result = 16'(Q16_MIN);
        end else begin
            result = value[15:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/ave_vol_div_scheduler_div.sv
// Radix-2 restoring divider on magnitudes; done arrives exactly DIV_LAT cycles after start.
module shift_div_seq
    import ave_vol_div_scheduler_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [31:0] dividend,
    input  logic        [15:0] divisor,
    output logic               done,
    output logic signed [31:0] quotient
);

    localparam logic [5:0] LAST_CNT = 6'(DIV_LAT - 2);

    logic        busy_r;
    logic [5:0]  cnt_r;
    logic [31:0] quo_r;
    logic [15:0] rem_r;
    logic [15:0] div_r;
    logic        neg_r;

    logic [31:0] mag_s;
    logic [16:0] rem_sh_s;
    logic        fits_s;
    logic [15:0] rem_nx_s;
    logic [31:0] quo_nx_s;
    logic [31:0] final_s;

    // One restoring step: the quotient register doubles as the dividend shifter
    always_comb begin
        mag_s    = dividend[31] ? (~dividend + 32'd1) : dividend;
        rem_sh_s = {rem_r, quo_r[31]};
        fits_s   = (rem_sh_s >= {1'b0, div_r});
        if (fits_s) begin
            rem_nx_s = 16'(rem_sh_s - {1'b0, div_r});
        end else begin
            rem_nx_s = rem_sh_s[15:0];
        end
        quo_nx_s = {quo_r[30:0], fits_s};
        if (cnt_r < 6'd32) begin
            final_s = quo_nx_s;
        end else begin
            final_s = quo_r;
        end
    end

    // Load on start, iterate 32 bits, then pad to DIV_LAT and apply sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r   <= 1'b0;
            cnt_r    <= 6'd0;
            quo_r    <= 32'd0;
            rem_r    <= 16'd0;
            div_r    <= 16'd0;
            neg_r    <= 1'b0;
            done     <= 1'b0;
            quotient <= 32'sd0;
        end else begin
            done <= 1'b0;
            if (!busy_r) begin
                if (start) begin
                    busy_r <= 1'b1;
                    cnt_r  <= 6'd0;
                    quo_r  <= mag_s;
                    rem_r  <= 16'd0;
                    div_r  <= divisor;
                    neg_r  <= dividend[31];
                end
            end else begin
                cnt_r <= cnt_r + 6'd1;
                if (cnt_r < 6'd32) begin
                    quo_r <= quo_nx_s;
                    rem_r <= rem_nx_s;
                end
                if (cnt_r == LAST_CNT) begin
                    busy_r   <= 1'b0;
                    done     <= 1'b1;
                    quotient <= neg_r ? (~final_s + 32'd1) : final_s;
                end
            end
        end
    end

endmodule

// File: rtl/ave_vol_div_scheduler.sv
// Runs phase A, B, C average divisions through one shared divider and publishes them atomically.
module ave_vol_div_scheduler
    import ave_vol_div_scheduler_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic               i_clk_20M,
    input  logic               i_reset_n,
    input  logic        [15:0] i_VCU_Mode,
    input  logic               i_calc_start,
    input  logic signed [31:0] i_TargetVolA,
    input  logic signed [31:0] i_TargetVolB,
    input  logic signed [31:0] i_TargetVolC,
    input  logic        [15:0] i_LinkNumA_Work,
    input  logic        [15:0] i_LinkNumB_Work,
    input  logic        [15:0] i_LinkNumC_Work,
    output logic signed [15:0] o_Ave_TargetVolA,
    output logic signed [15:0] o_Ave_TargetVolB,
    output logic signed [15:0] o_Ave_TargetVolC,
    output logic               o_valid,
    output logic               o_busy,
    output logic        [2:0]  o_div0_err,
    output logic               o_overrun
);

    state_t state_r, next_state_s;
    phase_t phase_r;

    logic signed [31:0] snap_vol_a_r, snap_vol_b_r, snap_vol_c_r;
    logic        [15:0] snap_num_a_r, snap_num_b_r, snap_num_c_r;
    logic signed [15:0] shadow_a_r, shadow_b_r;
    logic               err_a_r, err_b_r;

    logic               div_start_s;
    logic               div_done_s;
    logic signed [31:0] div_dividend_s;
    logic        [15:0] div_divisor_s;
    logic signed [31:0] div_quotient_s;
    logic signed [15:0] cur_avg_s;
    logic               cur_err_s;

    shift_div_seq #(.DIV_LAT(DIV_LAT)) u_div (
        .clk      (i_clk_20M),
        .rst_n    (i_reset_n),
        .start    (div_start_s),
        .dividend (div_dividend_s),
        .divisor  (div_divisor_s),
        .done     (div_done_s),
        .quotient (div_quotient_s)
    );

    // Operand select for the current phase and saturation of its result
    always_comb begin
        div_dividend_s = snap_vol_a_r;
        div_divisor_s  = snap_num_a_r;
        case (phase_r)
            PH_A: begin
                div_dividend_s = snap_vol_a_r;
                div_divisor_s  = snap_num_a_r;
            end
            PH_B: begin
                div_dividend_s = snap_vol_b_r;
                div_divisor_s  = snap_num_b_r;
            end
            PH_C: begin
                div_dividend_s = snap_vol_c_r;
                div_divisor_s  = snap_num_c_r;
            end
            default: begin
                div_dividend_s = 32'sd0;
                div_divisor_s  = 16'd0;
            end
        endcase
        cur_err_s = (div_divisor_s == 16'd0);
        if (cur_err_s) begin
            cur_avg_s = 16'sd0;
        end else begin
            cur_avg_s = sat_q16(div_quotient_s);
        end
    end

    // Next-state and divider start decode
    always_comb begin
        next_state_s = state_r;
        div_start_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_calc_start && (i_VCU_Mode != 16'd0)) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                div_start_s  = 1'b1;
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done_s) begin
                    next_state_s = ST_STORE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_STORE: begin
                if (phase_r == PH_C) begin
                    next_state_s = ST_PUBLISH;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            ST_PUBLISH: next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk_20M or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Snapshots, shadows and outputs; phase C's result goes straight to the outputs so they land with o_valid
    always_ff @(posedge i_clk_20M or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase_r          <= PH_A;
            snap_vol_a_r     <= 32'sd0;
            snap_vol_b_r     <= 32'sd0;
            snap_vol_c_r     <= 32'sd0;
            snap_num_a_r     <= 16'd0;
            snap_num_b_r     <= 16'd0;
            snap_num_c_r     <= 16'd0;
            shadow_a_r       <= 16'sd0;
            shadow_b_r       <= 16'sd0;
            err_a_r          <= 1'b0;
            err_b_r          <= 1'b0;
            o_Ave_TargetVolA <= 16'sd0;
            o_Ave_TargetVolB <= 16'sd0;
            o_Ave_TargetVolC <= 16'sd0;
            o_valid          <= 1'b0;
            o_busy           <= 1'b0;
            o_div0_err       <= 3'b000;
            o_overrun        <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_busy  <= (next_state_s != ST_IDLE);
            if (i_calc_start && o_busy) begin
                o_overrun <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (i_calc_start) begin
                        if (i_VCU_Mode == 16'd0) begin
                            o_Ave_TargetVolA <= 16'sd0;
                            o_Ave_TargetVolB <= 16'sd0;
                            o_Ave_TargetVolC <= 16'sd0;
                            o_div0_err       <= 3'b000;
                        end else begin
                            snap_vol_a_r <= i_TargetVolA;
                            snap_vol_b_r <= i_TargetVolB;
                            snap_vol_c_r <= i_TargetVolC;
                            snap_num_a_r <= i_LinkNumA_Work;
                            snap_num_b_r <= i_LinkNumB_Work;
                            snap_num_c_r <= i_LinkNumC_Work;
                            phase_r      <= PH_A;
                        end
                    end
                end
                ST_STORE: begin
                    case (phase_r)
                        PH_A: begin
                            shadow_a_r <= cur_avg_s;
                            err_a_r    <= cur_err_s;
                            phase_r    <= PH_B;
                        end
                        PH_B: begin
                            shadow_b_r <= cur_avg_s;
                            err_b_r    <= cur_err_s;
                            phase_r    <= PH_C;
                        end
                        PH_C: begin
                            o_Ave_TargetVolA <= shadow_a_r;
                            o_Ave_TargetVolB <= shadow_b_r;
                            o_Ave_TargetVolC <= cur_avg_s;
                            o_div0_err       <= {cur_err_s, err_b_r, err_a_r};
                            o_valid          <= 1'b1;
                        end
                        default: phase_r <= PH_A;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
